// File: rtl/kmeans_pkg.sv
// Shared defaults, FSM encoding and index-width helper for the k-means centroid update path.
package kmeans_pkg;

    localparam int K_DEF     = 8;
    localparam int D_DEF     = 4;
    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_DIV   = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/centroid_update_unit_if.sv
// Point/cluster stream, init load and centroid result bus of the centroid update unit.
// `converged` is present only when CENTROID_CONVERGE_EN is defined.
interface centroid_update_unit_if #(
    parameter int K = 8,
    parameter int D = 4,
    parameter int W = 8
);
    localparam int CLW = (K > 1) ? $clog2(K) : 1;

    logic                 init_we;
    logic [K*D*W-1:0]     init_centroid_flat;
    logic                 in_valid;
    logic                 in_ready;
    logic [D*W-1:0]       in_point_flat;
    logic [CLW-1:0]       in_cluster;
    logic                 in_last;
    logic [K*D*W-1:0]     centroid_flat;
    logic                 upd_valid;
    logic                 cnt_ovf;
`ifdef CENTROID_CONVERGE_EN
    logic                 converged;
`endif

    modport master (
        output init_we, init_centroid_flat, in_valid, in_point_flat, in_cluster, in_last,
`ifdef CENTROID_CONVERGE_EN
        input  converged,
`endif
        input  in_ready, centroid_flat, upd_valid, cnt_ovf
    );

    modport slave (
        input  init_we, init_centroid_flat, in_valid, in_point_flat, in_cluster, in_last,
`ifdef CENTROID_CONVERGE_EN
        output converged,
`endif
        output in_ready, centroid_flat, upd_valid, cnt_ovf
    );

endinterface

// File: rtl/kmeans_seq_div.sv
// Unsigned restoring divider: one quotient bit per cycle, SUM_W iterations after the start cycle.
module kmeans_seq_div #(
    parameter int SUM_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [SUM_W-1:0] i_dividend,
    input  logic [CNT_W-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [SUM_W-1:0] o_quot
);
    localparam int IT_W = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] r_quot;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] r_dvs;
    logic [IT_W-1:0]  r_iter;
    logic             r_busy;

    logic [CNT_W:0]   w_rem_sh;
    logic [CNT_W:0]   w_rem_sub;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_ge;
    logic [SUM_W-1:0] w_quot_nxt;

    assign w_rem_sh   = {r_rem, r_quot[SUM_W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_sub  = w_rem_sh - {1'b0, r_dvs};
    assign w_rem_nxt  = CNT_W'(w_ge ? w_rem_sub : w_rem_sh);
    assign w_quot_nxt = {r_quot[SUM_W-2:0], w_ge};

    // Final quotient is presented combinationally during the last iteration cycle.
    assign o_busy = r_busy;
    assign o_done = r_busy && (r_iter == IT_W'(1));
    assign o_quot = w_quot_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_iter <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_iter <= IT_W'(SUM_W);
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_quot <= w_quot_nxt;
            r_rem  <= w_rem_nxt;
            r_iter <= r_iter - IT_W'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/centroid_update_unit.sv
// Accumulates per-cluster sums/counts and divides them into new centroids at end of pass.
// Define CENTROID_CONVERGE_EN to add the `converged` flag on the bus.
module centroid_update_unit
    import kmeans_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int D     = D_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    centroid_update_unit_if.slave bus
);
    localparam int SUM_W = W + CNT_W;
    localparam int CLW   = f_idx_w(K);
    localparam int DLW   = f_idx_w(D);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  r_state, w_state_nxt;
    logic signed [W-1:0]     r_cent [K][D];
    logic signed [SUM_W-1:0] r_sum  [K][D];
    logic [CNT_W-1:0]        r_cnt  [K];
    logic [CLW-1:0]          r_k;
    logic [DLW-1:0]          r_d;
    logic                    r_ovf;

    logic signed [W-1:0]     w_pt [D];
    logic [CLW-1:0]          w_cluster;
    logic signed [SUM_W-1:0] w_cur_sum;
    logic [SUM_W-1:0]        w_sum_u, w_abs_sum, w_div_quot;
    logic signed [W-1:0]     w_mean;
    logic w_last_k, w_last_d, w_elem_empty, w_div_start, w_div_busy, w_div_done, w_elem_adv;

    // Quotient of |sum| is truncated toward zero; reapply the sign of the sum.
    function automatic logic signed [W-1:0] f_signed_mean(input logic [SUM_W-1:0] quot,
                                                          input logic neg);
        logic [SUM_W-1:0] v;
        v = neg ? (~quot + SUM_W'(1)) : quot;
        return W'(v);
    endfunction

    always_comb begin
        for (int d = 0; d < D; d++) w_pt[d] = bus.in_point_flat[d*W +: W];
    end

    assign w_cluster    = bus.in_cluster;
    assign w_cur_sum    = r_sum[r_k][r_d];
    assign w_sum_u      = w_cur_sum;
    assign w_abs_sum    = w_cur_sum[SUM_W-1] ? (~w_sum_u + SUM_W'(1)) : w_sum_u;
    assign w_mean       = f_signed_mean(w_div_quot, w_cur_sum[SUM_W-1]);
    assign w_elem_empty = (r_cnt[r_k] == '0);
    assign w_last_k     = (r_k == CLW'(K - 1));
    assign w_last_d     = (r_d == DLW'(D - 1));

    kmeans_seq_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_abs_sum),
        .i_divisor  (r_cnt[r_k]),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_elem_adv  = 1'b0;
        case (r_state)
            S_ACCUM: if (bus.in_valid && bus.in_last && !bus.init_we) w_state_nxt = S_DIV;
            S_DIV: begin
                if (w_div_busy)        w_elem_adv  = w_div_done;
                else if (w_elem_empty) w_elem_adv  = 1'b1;
                else                   w_div_start = 1'b1;
                if (w_elem_adv && w_last_k && w_last_d) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_ACCUM;
            default: w_state_nxt = S_ACCUM;
        endcase
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.upd_valid = (r_state == S_DONE);
    assign bus.cnt_ovf   = r_ovf;

    always_comb begin
        bus.centroid_flat = '0;
        for (int k = 0; k < K; k++)
            for (int d = 0; d < D; d++) bus.centroid_flat[(k*D+d)*W +: W] = r_cent[k][d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                r_cnt[k] <= '0;
                for (int d = 0; d < D; d++) begin
                    r_cent[k][d] <= '0;
                    r_sum[k][d]  <= '0;
                end
            end
            r_ovf <= 1'b0;
            r_k   <= '0;
            r_d   <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    r_k <= '0;
                    r_d <= '0;
                    if (bus.init_we) begin
                        for (int k = 0; k < K; k++) begin
                            r_cnt[k] <= '0;
                            for (int d = 0; d < D; d++) begin
                                r_cent[k][d] <= bus.init_centroid_flat[(k*D+d)*W +: W];
                                r_sum[k][d]  <= '0;
                            end
                        end
                        r_ovf <= 1'b0;
                    end else if (bus.in_valid) begin
                        // A saturated cluster drops the whole pair so sum and count stay consistent.
                        if (r_cnt[w_cluster] == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt[w_cluster] <= r_cnt[w_cluster] + CNT_W'(1);
                            for (int d = 0; d < D; d++)
                                r_sum[w_cluster][d] <= r_sum[w_cluster][d] + SUM_W'(w_pt[d]);
                        end
                    end
                end
                S_DIV: begin
                    if (w_div_done) r_cent[r_k][r_d] <= w_mean;
                    if (w_elem_adv) begin
                        if (w_last_d) begin
                            r_d <= '0;
                            r_k <= w_last_k ? '0 : r_k + CLW'(1);
                        end else begin
                            r_d <= r_d + DLW'(1);
                        end
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < K; k++) begin
                        r_cnt[k] <= '0;
                        for (int d = 0; d < D; d++) r_sum[k][d] <= '0;
                    end
                    r_ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CENTROID_CONVERGE_EN
    logic r_changed;
    logic r_conv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
            r_conv    <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_conv    <= !r_changed;
            r_changed <= 1'b0;
        end else if (r_state == S_DIV && w_div_done && (w_mean != r_cent[r_k][r_d])) begin
            r_changed <= 1'b1;
        end
    end

    assign bus.converged = r_conv;
`endif

endmodule

// File: tb/tb_centroid_update_unit.sv
// Directed and randomized bench for centroid_update_unit against a sum/count/mean reference model.
module tb_centroid_update_unit;
    localparam int K = 8, D = 4, W = 8, CNT_W = 4;
    localparam int ELEM_CYC = W + CNT_W + 1;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    centroid_update_unit_if #(.K(K), .D(D), .W(W)) bus ();
    centroid_update_unit #(.K(K), .D(D), .W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    int m_cent [K][D];
    int m_sum  [K][D];
    int m_cnt  [K];
    bit m_ovf;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_flat();
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < K; k++)
            for (int d = 0; d < D; d++) f[(k*D+d)*W +: W] = 8'(m_cent[k][d]);
        return f;
    endfunction

    function automatic int rnd_coord();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic model_clear(input bit all);
        for (int k = 0; k < K; k++) begin
            m_cnt[k] = 0;
            for (int d = 0; d < D; d++) begin
                m_sum[k][d] = 0;
                if (all) m_cent[k][d] = 0;
            end
        end
        m_ovf = 1'b0;
    endtask

    task automatic send(input int p0, input int p1, input int p2, input int p3,
                        input int c, input bit last);
        int p[4];
        p = '{p0, p1, p2, p3};
        for (int d = 0; d < D; d++) bus.in_point_flat[d*W +: W] = 8'(p[d]);
        bus.in_cluster = 3'(c);
        bus.in_last    = last;
        bus.in_valid   = 1'b1;
        if (bus.in_ready) begin
            if (m_cnt[c] == CMAX) m_ovf = 1'b1;
            else begin
                m_cnt[c]++;
                for (int d = 0; d < D; d++) m_sum[c][d] += p[d];
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic load_init(input logic [255:0] val);
        bus.init_we            = 1'b1;
        bus.init_centroid_flat = val;
        @(posedge clk); #1;
        bus.init_we = 1'b0;
        model_clear(1'b0);
        for (int k = 0; k < K; k++)
            for (int d = 0; d < D; d++) m_cent[k][d] = int'($signed(val[(k*D+d)*W +: W]));
    endtask

    // Called one cycle after the last pair was accepted; the unit is dividing.
    task automatic finish_pass(input bit hold);
        int n, len, q;
        len = 0;
        for (int k = 0; k < K; k++) len += D * ((m_cnt[k] != 0) ? ELEM_CYC : 1);
        if (hold) begin
            bus.in_valid      = 1'b1;
            bus.in_last       = 1'b1;
            bus.in_point_flat = 32'($urandom);
            bus.in_cluster    = 3'($urandom_range(0, 7));
        end
        chk("div_ready_low", bus.in_ready, 0);
        n = 0;
        while (!bus.upd_valid && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("div_len", n, len);
        for (int k = 0; k < K; k++)
            for (int d = 0; d < D; d++)
                if (m_cnt[k] != 0) begin
                    q = ((m_sum[k][d] < 0) ? -m_sum[k][d] : m_sum[k][d]) / m_cnt[k];
                    m_cent[k][d] = (m_sum[k][d] < 0) ? -q : q;
                end
        chk("centroids", bus.centroid_flat, exp_flat());
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_clear(1'b0);
        @(posedge clk); #1;
        chk("upd_pulse_end", bus.upd_valid, 0);
        chk("ovf_cleared", bus.cnt_ovf, 0);
        chk("ready_back", bus.in_ready, 1);
    endtask

    initial begin
        logic [255:0] init_v;
        logic [31:0]  c5_before;
        int npairs, c, n, seen;

        rst = 1'b1;
        bus.init_we = 1'b0;
        bus.init_centroid_flat = '0;
        bus.in_valid = 1'b0;
        bus.in_point_flat = '0;
        bus.in_cluster = '0;
        bus.in_last = 1'b0;
        model_clear(1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_upd", bus.upd_valid, 0);
        chk("rst_ovf", bus.cnt_ovf, 0);
        chk("rst_cent", bus.centroid_flat, 0);

        init_v = {32{8'h10}};
        load_init(init_v);
        chk("init_cent", bus.centroid_flat, init_v);
        send(4, 8, -2, 6, 3, 1'b1);
        finish_pass(1'b0);
        chk("c3_mean", bus.centroid_flat[3*32 +: 32], 32'h06FE0804);

        // Dim0 truncation toward zero for both signs; in_valid held through the division.
        send(3, 1, 0, 0, 0, 1'b0);
        send(4, 1, 0, 0, 0, 1'b0);
        send(-3, 0, 0, 0, 1, 1'b0);
        send(-4, 0, 0, 0, 1, 1'b1);
        finish_pass(1'b1);
        chk("c0_d0_trunc", bus.centroid_flat[7:0], 8'h03);
        chk("c1_d0_trunc", bus.centroid_flat[39:32], 8'hFD);

        for (int r = 0; r < 3; r++) begin
            c5_before = exp_flat() >> (5*32);
            npairs = $urandom_range(1, 20);
            for (int i = 0; i < npairs; i++) begin
                c = $urandom_range(0, 6);
                if (c >= 5) c++;
                send(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), c, i == npairs - 1);
            end
            finish_pass(1'b0);
            chk("c5_keep", bus.centroid_flat[5*32 +: 32], c5_before);
        end

        for (int i = 0; i < CMAX; i++)
            send(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), 2, 1'b0);
        chk("ovf_not_yet", bus.cnt_ovf, m_ovf);
        send(127, 127, 127, 127, 2, 1'b0);
        chk("ovf_set", bus.cnt_ovf, 1);
        send(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(), 0, 1'b1);
        chk("ovf_sticky_div", bus.cnt_ovf, 1);
        finish_pass(1'b0);

        // init_we beats a same-cycle pair, including its in_last.
        init_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.in_point_flat = 32'h7F7F7F7F;
        bus.in_cluster    = 3'd1;
        bus.in_last       = 1'b1;
        bus.in_valid      = 1'b1;
        load_init(init_v);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("init_beats_ready", bus.in_ready, 1);
        chk("init_beats_cent", bus.centroid_flat, init_v);
        send(-20, 10, 5, -1, 1, 1'b1);
        finish_pass(1'b0);

        send(50, 60, 70, 80, 4, 1'b1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear(1'b1);
        chk("midrst_cent", bus.centroid_flat, exp_flat());
        chk("midrst_ready", bus.in_ready, 1);
        chk("midrst_upd", bus.upd_valid, 0);
        seen = 0;
        for (n = 0; n < 120; n++) begin
            if (bus.upd_valid) seen++;
            @(posedge clk); #1;
        end
        chk("midrst_no_upd", seen, 0);

`ifdef CENTROID_CONVERGE_EN
        for (int r = 0; r < 2; r++) begin
            send(10, 20, 30, 40, 0, 1'b0);
            send(12, -20, 31, 41, 0, 1'b0);
            send(-5, -6, -7, -9, 6, 1'b1);
            finish_pass(1'b0);
            chk("converged", bus.converged, (r == 1) ? 1 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
